// File: rtl/munoc_rle_packer_pkg.sv
// Run-length helpers shared by the munoc packer and the token comparator.
// Both ends take the count encoding from here so that they always agree.
package munoc_rle_packer_pkg;

   // What an offered beat does to the pending run.
   typedef enum logic [1:0] {
      ACT_START  = 2'd0,
      ACT_EXTEND = 2'd1,
      ACT_SPLIT  = 2'd2
   } rle_action_e;

   // Longest run that one token can carry.
   function automatic int unsigned rle_maxlen(input int unsigned bw_count, input bit zero_based);
      int unsigned full;
      full = 32'd1 << bw_count;
      return zero_based ? full : full - 32'd1;
   endfunction

   // Count field for a true run length; callers truncate it to their field width.
   function automatic int unsigned rle_encode(input int unsigned run_len, input bit zero_based);
      return zero_based ? run_len - 32'd1 : run_len;
   endfunction

endpackage

// File: rtl/munoc_rle_token_reg.sv
// One-entry valid/ready token register: it loads, holds while stalled, and clears once drained.
// The caller loads it only when the slot is free; enable=0 freezes it completely.
module munoc_rle_token_reg #(
   parameter int BW_DATA  = 32,
   parameter int BW_COUNT = 1
) (
   input  logic                clk,
   input  logic                rstnn,
   input  logic                enable,
   input  logic                load,
   input  logic [BW_DATA-1:0]  load_data,
   input  logic [BW_COUNT-1:0] load_count,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BW_DATA-1:0]  out_data,
   output logic [BW_COUNT-1:0] out_count
);

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else if (enable) begin
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/munoc_rle_packer.sv
// Folds a raw beat stream into {count, data} run-length tokens.
// The pending run and the idle timer live here; finished tokens go to munoc_rle_token_reg.
module munoc_rle_packer
   import munoc_rle_packer_pkg::*;
#(
   parameter int BW_DATA      = 32,
   parameter int BW_COUNT     = 1,
   parameter int ZERO_BASED   = 0,
   parameter int IDLE_TIMEOUT = 0,
   parameter int BW_TIMER     = 8
) (
   input  logic                clk,
   input  logic                rstnn,
   input  logic                enable,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BW_DATA-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BW_DATA-1:0]  out_data,
   output logic [BW_COUNT-1:0] out_count,
   output logic                idle
);

   // One extra bit so that the zero-based maximum 2^BW_COUNT still fits.
   localparam int BW_LEN = BW_COUNT + 1;
   localparam bit ZB = (ZERO_BASED != 0);
   localparam logic [BW_LEN-1:0]   MAX_LEN     = BW_LEN'(rle_maxlen(BW_COUNT, ZB));
   localparam logic [BW_LEN-1:0]   LEN_ONE     = BW_LEN'(1);
   localparam logic [BW_TIMER-1:0] TIMEOUT_VAL = BW_TIMER'(IDLE_TIMEOUT);
   localparam logic [BW_TIMER-1:0] TIMER_ONE   = BW_TIMER'(1);

   logic                pvalid;
   logic [BW_DATA-1:0]  pdata;
   logic [BW_LEN-1:0]   plen;
   logic [BW_TIMER-1:0] timer;

   rle_action_e         action;
   logic                slot_free;
   logic                timeout_hit;
   logic                flush_eff;
   logic                accept;
   logic                emit;
   logic [BW_COUNT-1:0] emit_count;

   always_comb begin
      slot_free   = ~out_valid | out_ready;
      timeout_hit = (IDLE_TIMEOUT > 0) && pvalid && (timer == TIMEOUT_VAL);
      flush_eff   = flush | timeout_hit;

      action = ACT_SPLIT;
      if (!pvalid) begin
         action = ACT_START;
      end else if ((in_data == pdata) && (plen < MAX_LEN)) begin
         action = ACT_EXTEND;
      end

      // Only SPLIT needs the output slot, so EXTEND/START keep flowing under backpressure.
      in_ready   = rstnn & enable & ~flush_eff & ((action != ACT_SPLIT) | slot_free);
      accept     = in_valid & in_ready;
      emit       = enable & pvalid & slot_free & ((accept & (action == ACT_SPLIT)) | flush_eff);
      emit_count = BW_COUNT'(rle_encode(32'(plen), ZB));
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         pvalid <= 1'b0;
         pdata  <= '0;
         plen   <= '0;
         timer  <= '0;
      end else if (enable) begin
         if (accept) begin
            if (action == ACT_EXTEND) begin
               plen <= plen + LEN_ONE;
            end else begin
               pvalid <= 1'b1;
               pdata  <= in_data;
               plen   <= LEN_ONE;
            end
         end else if (emit) begin
            pvalid <= 1'b0;
            plen   <= '0;
         end

         // The timer saturates at the timeout so a stalled emission keeps retrying.
         if (accept || emit || !pvalid) begin
            timer <= '0;
         end else if (timer != TIMEOUT_VAL) begin
            timer <= timer + TIMER_ONE;
         end
      end
   end

   munoc_rle_token_reg #(
      .BW_DATA  (BW_DATA),
      .BW_COUNT (BW_COUNT)
   ) u_token_reg (
      .clk        (clk),
      .rstnn      (rstnn),
      .enable     (enable),
      .load       (emit),
      .load_data  (pdata),
      .load_count (emit_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_count  (out_count)
   );

   assign idle = ~pvalid & ~out_valid;

endmodule

// File: doc/munoc_rle_packer.md
Name: munoc_rle_packer

Overview:
- Run-length packer that folds a raw beat stream into {count, data} tokens.
- Identical consecutive beats collapse into one token whose count field gives the run length.
- Sits directly upstream of the dual-stream token comparator in the munoc checking path; its count encoding matches that comparator's repeat counter.
- Typical use: one instance per compared stream, e.g. expected vs. actual NoC trace.

Parameters:
- BW_DATA, 32, width of beat data and token data.
- BW_COUNT, 1, width of the token count field.
- ZERO_BASED, 0: 0 = count field equals run length (1..2^BW_COUNT-1); 1 = count field equals run length-1 (0..2^BW_COUNT-1).
- IDLE_TIMEOUT, 0: cycles without an accepted beat after which a pending run is emitted automatically; 0 disables the timeout.
- BW_TIMER, 8, width of the idle timer; IDLE_TIMEOUT must be < 2^BW_TIMER.

Ports:
- clk  input  1  clock
- rstnn  input  1  asynchronous active-low reset
- enable  input  1  global enable; when 0 all state holds and in_ready=0
- flush  input  1  level request to emit the pending run
- in_valid  input  1  raw beat valid
- in_ready  output  1  raw beat accepted when in_valid&in_ready
- in_data  input  BW_DATA  raw beat
- out_valid  output  1  token valid
- out_ready  input  1  downstream accepts token
- out_data  output  BW_DATA  token data
- out_count  output  BW_COUNT  encoded run length
- idle  output  1  no pending run and no token held

Behaviour:
- Reset: out_valid=0, out_data=0, out_count=0, pending run cleared, timer=0, idle=1, in_ready=0 while rstnn=0.
- Internal state:
  - Pending register: pvalid, pdata, plen; plen is the true length.
  - One-entry output register: out_valid/out_data/out_count.
- MAXLEN = 2^BW_COUNT-1 if ZERO_BASED=0, else 2^BW_COUNT.
- Encoding: out_count = plen if ZERO_BASED=0, else plen-1; truncated to BW_COUNT.
- slot_free = ~out_valid | out_ready.
- Beat handling (only when enable=1 and flush=0):
  - EXTEND: pvalid & in_data==pdata & plen<MAXLEN → in_ready=1; on accept plen+=1.
  - START: ~pvalid → in_ready=1; on accept pdata=in_data, plen=1, pvalid=1.
  - SPLIT: pvalid & (in_data!=pdata | plen==MAXLEN) → in_ready=slot_free.
    - On accept, the pending run moves to the output register and the new beat starts plen=1, in the same cycle.
- in_ready depends combinationally on in_data; in_valid must not depend on in_ready.
- Flush: while flush=1 and enable=1, in_ready=0.
  - If pvalid & slot_free, the pending run moves to the output register and pvalid clears.
  - A flush with no pending run is a no-op.
- Timeout (IDLE_TIMEOUT>0):
  - The timer resets to 0 on every accepted beat or emission, and increments while pvalid & enable with no accept.
  - When timer==IDLE_TIMEOUT, the block behaves as flush for that cycle; the timer saturates until the emission happens.
- Output register:
  - Loads only when slot_free. Holds data/count stable while out_valid & ~out_ready.
  - Clears out_valid on out_valid&out_ready with no new load.
- Latency: a token appears on out_valid one cycle after the terminating event (SPLIT accept, flush, or timeout).
- Throughput: one beat per cycle, and one token per cycle when every beat differs.
- Backpressure: EXTEND and START continue while the output is stalled; only SPLIT and flush stall.
- Saturation: a run longer than MAXLEN is emitted as MAXLEN tokens followed by the remainder; never wraps.
- enable=0: no state change, timer frozen; out_valid/out_data/out_count hold their values.
- idle = ~pvalid & ~out_valid.
- Reset mid-run discards the pending run and the held token.

Decomposition:
- Shared munoc package:
  - maxlen function (BW_COUNT, ZERO_BASED).
  - Count-encoding function, reused by the comparator side so both ends agree.
- Sub-module: munoc_rle_token_reg, the one-entry valid/ready output register with load/hold/clear.
- The pending-run register and timer stay in the top-level module.

Test Plan:
- BW_COUNT=4, ZERO_BASED=0, out_ready=1; beats A,A,A,B then flush → tokens {3,A}, {1,B}; idle=1 afterwards.
- Same configuration, 20 consecutive A beats then flush → tokens {15,A}, {5,A}; in_ready never drops.
- ZERO_BASED=1, BW_COUNT=1; beats A,A,A → tokens {1,A} (length 2), then {0,A} (length 1) on flush.
- out_ready=0 with token {2,A} held; feed B,B (accepted, EXTEND) then C → in_ready=0 until out_ready=1. Next cycle out shows {2,B}.
- IDLE_TIMEOUT=4; beat A, then no input → token {1,A} valid exactly 6 cycles after the accept cycle; no further tokens follow.
- enable=0 for 3 cycles mid-run (A,A pending), then rstnn pulse → out_valid=0 and idle=1. A subsequent flush produces no token.
